proc_port_responder: RTL
========================

Name: proc_port_responder

Overview:
- Synthesizable responder for the processor side of the cache request interface. It accepts the same requests the processor issues to the cache and answers them:
  - Request struct fields: cs, rw, addr, data, flush.
  - Response: proc_res.hold_cpu plus proc_res_data.
- It is backed by a local word-addressed scratchpad with programmable wait states and dirty tracking.
- Used as an uncached/bypass target and as a golden stand-in for the cache when bringing up processor-side drivers.

Parameters:
- LATENCY, 2, wait-state cycles inserted before a load or store completes (0 allowed).
- IDX_WIDTH, 10, scratchpad index width; DEPTH = 2**IDX_WIDTH words.
- DATA_WIDTH and ADDR_WIDTH are not parameters; they come from cache_structs_def.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- proc_req  in  processor_request_t  processor request (cs, rw, addr, data, flush).
- proc_res  out  processor_response_t  hold_cpu stall indication; other fields driven to 0.
- proc_res_data  out  DATA_WIDTH  load data.
- flush_count  out  IDX_WIDTH+1  number of dirty words found by the last flush.
- req_count  out  32  completed load/store count, wraps at 2**32.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hold_cpu=0; proc_res_data=0; flush_count=0; req_count=0.
  - All dirty bits cleared; wait counter=0.
  - Scratchpad contents are not reset.
- Address: index = proc_req.addr[IDX_WIDTH-1:0] (word address). Upper bits are ignored, so addresses alias modulo DEPTH.
- hold_cpu is combinational: 1 when (state==IDLE && cs==1) or state==BUSY or state==FLUSH; otherwise 0.
  - A driver therefore sees the stall within the cycle it presents a request.
- FSM states: IDLE, BUSY, FLUSH, DONE.
- IDLE:
  - cs=0: stay.
  - cs=1 and flush=1: capture nothing, clear flush counter, scan index=0, go to FLUSH. Flush wins over rw.
  - cs=1, flush=0, LATENCY>0: latch rw/addr/data, counter=LATENCY-1, go to BUSY.
  - cs=1, flush=0, LATENCY=0: perform the access at this edge, go to DONE.
- BUSY:
  - counter>0: decrement.
  - counter==0, store: write latched data at latched index, set its dirty bit.
  - counter==0, load: register proc_res_data <= mem[index].
  - In both cases req_count++ and go to DONE.
  - Request inputs are ignored while BUSY; the latched copy is used.
- DONE:
  - hold_cpu=0; proc_res_data is stable and valid for loads.
  - Always return to IDLE on the next edge, so a request still held with cs=1 is serviced again as a new request.
- FLUSH:
  - One index per cycle, 0..DEPTH-1: if the dirty bit is set, clear it and increment the internal count.
  - After index DEPTH-1, publish flush_count and go to DONE.
  - Duration is exactly DEPTH cycles of hold_cpu=1.
- Stores do not change proc_res_data; it keeps the last load value.
- Read-after-write to the same index in consecutive requests returns the new data.
- Reset asserted mid-BUSY or mid-FLUSH:
  - Immediate return to IDLE; hold_cpu drops asynchronously.
  - An in-flight store is not written; a partial flush leaves flush_count=0.
- Memory is inferred as a single-port synchronous RAM: one access per cycle, read registered.

Decomposition:
- Package cache_structs_def keeps processor_request_t, processor_response_t, DATA_WIDTH, ADDR_WIDTH.
- Add to the same package: responder_state_t enum {IDLE, BUSY, FLUSH, DONE}.
- One sub-module: responder_spram (single-port RAM with registered read, DEPTH x DATA_WIDTH), so the storage maps cleanly to block RAM.
- The FSM, dirty bits and counters stay in the top.

Test Plan:
- Reset then idle (rst low 1 cycle, cs=0) -> hold_cpu=0, proc_res_data=0, req_count=0, flush_count=0.
- ST addr=0x004 data=0xDEADBEEF, LATENCY=2 -> hold_cpu=1 for 3 cycles (IDLE+2 BUSY), then DONE. Follow-up LD 0x004 -> proc_res_data=0xDEADBEEF; req_count=2.
- Aliasing, IDX_WIDTH=10: ST 0x405=0x11 then LD 0x005 -> 0x11.
- Flush after stores to indices 1, 2 and 1 again (IDX_WIDTH=4) -> hold_cpu=1 for exactly 16 cycles, flush_count=2. A second flush immediately after -> flush_count=0.
- LATENCY=0 with back-to-back LD/ST alternating over 8 addresses -> no BUSY cycles, each request completes in 1 cycle plus DONE, data matches a scoreboard.
- rst asserted on the 2nd BUSY cycle of ST 0x010=0xA5 -> hold_cpu=0 immediately. Later LD 0x010 returns the prior contents, not 0xA5; req_count=0.

Source files
------------

// File: rtl/cache_structs_def.sv
// Shared processor-side cache request/response types plus the responder FSM state.
// Ports: none (package).
package cache_structs_def;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    // rw encoding: 0 = load, 1 = store
    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef struct packed {
        logic                  cs;
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  flush;
    } processor_request_t;

    typedef struct packed {
        logic                  hold_cpu;
        logic [DATA_WIDTH-1:0] data;
    } processor_response_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } responder_state_t;

endpackage

// File: rtl/proc_port_responder_if.sv
// Processor-side request/response bundle of the responder.
// master = processor driver (drives proc_req), slave = responder.
// Ports: none; signals proc_req, proc_res, proc_res_data, flush_count, req_count.
interface proc_port_responder_if #(
    parameter int IDX_WIDTH = 10
);
    import cache_structs_def::*;

    processor_request_t              proc_req;
    processor_response_t             proc_res;
    logic [DATA_WIDTH-1:0]           proc_res_data;
    logic [IDX_WIDTH:0]              flush_count;
    logic [31:0]                     req_count;

    modport master (
        output proc_req,
        input  proc_res,
        input  proc_res_data,
        input  flush_count,
        input  req_count
    );

    modport slave (
        input  proc_req,
        output proc_res,
        output proc_res_data,
        output flush_count,
        output req_count
    );

endinterface

// File: rtl/responder_spram.sv
// Single-port synchronous RAM, registered read, one access per cycle.
// Ports: clk, en (access enable), we (1 = write), addr, wdata, q (read data,
// holds its value when no read is performed). Contents are never reset.
module responder_spram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem_r [2**AW];

    // Single-port access: write, or registered read that holds otherwise
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                q <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/proc_port_responder.sv
// Processor-port responder: answers cache-style requests from a local
// word-addressed scratchpad with programmable wait states and dirty tracking.
// Ports: clk, rst (async active-low), bus (slave modport: proc_req in;
// proc_res, proc_res_data, flush_count, req_count out).
module proc_port_responder
    import cache_structs_def::*;
#(
    parameter int LATENCY   = 2,
    parameter int IDX_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    proc_port_responder_if.slave bus
);

    localparam int DEPTH = 2 ** IDX_WIDTH;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : {CNT_W{1'b0}};
    localparam logic ZERO_LAT = (LATENCY == 0);

    responder_state_t      state_r;
    logic                  rw_r;
    logic [IDX_WIDTH-1:0]  idx_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [CNT_W-1:0]      wait_cnt_r;
    logic [IDX_WIDTH-1:0]  scan_r;
    logic [IDX_WIDTH:0]    count_r;
    logic [IDX_WIDTH:0]    flush_count_r;
    logic [31:0]           req_count_r;
    logic [DEPTH-1:0]      dirty_r;
    logic                  load_seen_r;

    logic [IDX_WIDTH-1:0]  req_idx_s;
    logic                  hold_s;
    logic                  ram_en_s;
    logic                  ram_we_s;
    logic [IDX_WIDTH-1:0]  ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic [DATA_WIDTH-1:0] ram_q_s;
    logic [DATA_WIDTH-1:0] res_data_s;
    logic [IDX_WIDTH:0]    count_next_s;
    processor_response_t   res_s;
    logic                  unused_addr_s;

    // Upper address bits alias; only the word index is decoded.
    assign req_idx_s     = bus.proc_req.addr[IDX_WIDTH-1:0];
    assign unused_addr_s = ^bus.proc_req.addr[ADDR_WIDTH-1:IDX_WIDTH];

    // Stall indication; gated by rst so it drops the moment reset asserts
    always_comb begin
        hold_s = 1'b0;
        if (!rst) begin
            hold_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    hold_s = bus.proc_req.cs;
                BUSY:    hold_s = 1'b1;
                FLUSH:   hold_s = 1'b1;
                DONE:    hold_s = 1'b0;
                default: hold_s = 1'b0;
            endcase
        end
    end

    // RAM port control: direct access from IDLE when zero-latency, else the latched request
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = rw_r;
        ram_addr_s  = idx_r;
        ram_wdata_s = wdata_r;
        if (!rst) begin
            ram_en_s = 1'b0;
        end else if (state_r == IDLE) begin
            ram_addr_s  = req_idx_s;
            ram_we_s    = bus.proc_req.rw;
            ram_wdata_s = bus.proc_req.data;
            ram_en_s    = ZERO_LAT & bus.proc_req.cs & ~bus.proc_req.flush;
        end else if (state_r == BUSY) begin
            ram_en_s = (wait_cnt_r == {CNT_W{1'b0}});
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // Running dirty-word tally for the flush scan position
    always_comb begin
        count_next_s = count_r + {{IDX_WIDTH{1'b0}}, dirty_r[scan_r]};
    end

    // Load data is the RAM's read register; zero until the first load after reset
    always_comb begin
        res_data_s = {DATA_WIDTH{1'b0}};
        if (load_seen_r) begin
            res_data_s = ram_q_s;
        end else begin
            res_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Response struct: only hold_cpu carries information
    always_comb begin
        res_s          = '0;
        res_s.hold_cpu = hold_s;
    end

    assign bus.proc_res      = res_s;
    assign bus.proc_res_data = res_data_s;
    assign bus.flush_count   = flush_count_r;
    assign bus.req_count     = req_count_r;

    // Main FSM with wait counter, dirty bits, flush scan and statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            rw_r          <= RW_LOAD;
            idx_r         <= {IDX_WIDTH{1'b0}};
            wdata_r       <= {DATA_WIDTH{1'b0}};
            wait_cnt_r    <= {CNT_W{1'b0}};
            scan_r        <= {IDX_WIDTH{1'b0}};
            count_r       <= {(IDX_WIDTH+1){1'b0}};
            flush_count_r <= {(IDX_WIDTH+1){1'b0}};
            req_count_r   <= 32'd0;
            dirty_r       <= {DEPTH{1'b0}};
            load_seen_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.proc_req.cs) begin
                        if (bus.proc_req.flush) begin
                            // The request cycle itself scans index 0, so the whole
                            // flush stalls the processor for exactly DEPTH cycles.
                            count_r    <= {{IDX_WIDTH{1'b0}}, dirty_r[0]};
                            dirty_r[0] <= 1'b0;
                            scan_r     <= IDX_WIDTH'(1'b1);
                            state_r    <= FLUSH;
                        end else if (ZERO_LAT) begin
                            req_count_r <= req_count_r + 32'd1;
                            if (bus.proc_req.rw == RW_STORE) begin
                                dirty_r[req_idx_s] <= 1'b1;
                            end else begin
                                load_seen_r <= 1'b1;
                            end
                            state_r <= DONE;
                        end else begin
                            rw_r       <= bus.proc_req.rw;
                            idx_r      <= req_idx_s;
                            wdata_r    <= bus.proc_req.data;
                            wait_cnt_r <= WAIT_INIT;
                            state_r    <= BUSY;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (wait_cnt_r != {CNT_W{1'b0}}) begin
                        wait_cnt_r <= wait_cnt_r - CNT_W'(1'b1);
                    end else begin
                        req_count_r <= req_count_r + 32'd1;
                        if (rw_r == RW_STORE) begin
                            dirty_r[idx_r] <= 1'b1;
                        end else begin
                            load_seen_r <= 1'b1;
                        end
                        state_r <= DONE;
                    end
                end
                FLUSH: begin
                    dirty_r[scan_r] <= 1'b0;
                    if (&scan_r) begin
                        flush_count_r <= count_next_s;
                        state_r       <= DONE;
                    end else begin
                        count_r <= count_next_s;
                        scan_r  <= scan_r + IDX_WIDTH'(1'b1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    responder_spram #(
        .AW (IDX_WIDTH),
        .DW (DATA_WIDTH)
    ) u_spram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .q     (ram_q_s)
    );

endmodule
